// File: rtl/rr_arbiter8_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8_if
//  Description : Request/grant bundle between requesters and the 8-way
//                round-robin arbiter driving a 3-to-8 decoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface rr_arbiter8_if;
  logic [7:0] req;            // level-sensitive request per channel
  logic       release_grant;  // granted requester ends its grant ("release" is a reserved word)
  logic [2:0] sel;            // granted channel index (decoder select)
  logic       oe;             // grant valid (decoder output enable)
  logic       timeout;        // one-cycle pulse after a hold-limit forced end
  logic [2:0] ptr;            // round-robin search start (debug)

  // Requester side
  modport master (
    output req, release_grant,
    input  sel, oe, timeout, ptr
  );

  // Arbiter side
  modport slave (
    input  req, release_grant,
    output sel, oe, timeout, ptr
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : 8-channel round-robin arbiter with optional maximum grant
//                length. Two-state FSM (IDLE/GRANT), registered outputs,
//                mandatory idle cycle between grants.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16  // maximum grant length in cycles, 0 = unlimited
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter8_if.slave  bus
);

  // Counter only needs to reach MAX_HOLD-1; keep at least one bit so the
  // unlimited configuration still elaborates cleanly.
  localparam int HW          = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HW-1:0] HOLD_LAST = HOLD_LAST_I[HW-1:0];

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, nxt_state;
  logic [2:0]    sel_q, nxt_sel;
  logic [2:0]    ptr_q, nxt_ptr;
  logic [HW-1:0] hold_q, nxt_hold;
  logic          timeout_q, nxt_timeout;

  logic [2:0]    cand;
  logic [2:0]    win_idx;
  logic          win_found;
  logic          withdrawn;
  logic          at_limit;

  // Round-robin search: first asserted request starting at ptr and wrapping.
  always_comb begin
    cand      = 3'd0;
    win_idx   = ptr_q;
    win_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + k[2:0];
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant-end conditions evaluated against the currently granted channel.
  always_comb begin
    withdrawn = ~bus.req[sel_q];
    at_limit  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  end

  // Next-state and next-register logic; everything holds unless changed.
  always_comb begin
    nxt_state   = state;
    nxt_sel     = sel_q;
    nxt_ptr     = ptr_q;
    nxt_hold    = hold_q;
    nxt_timeout = 1'b0;
    case (state)
      IDLE: begin
        // release is deliberately ignored here
        if (win_found) begin
          nxt_state = GRANT;
          nxt_sel   = win_idx;
          nxt_ptr   = win_idx + 3'd1;
          nxt_hold  = '0;
        end
      end
      GRANT: begin
        // req is not re-arbitrated while granted; only req[sel] matters
        if (bus.release_grant || withdrawn || at_limit) begin
          nxt_state   = IDLE;
          // Pulse only when the limit alone ended the grant
          nxt_timeout = at_limit && !bus.release_grant && !withdrawn;
        end else begin
          nxt_hold = hold_q + HW'(1);
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 3'd0;
      ptr_q     <= 3'd0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= nxt_state;
      sel_q     <= nxt_sel;
      ptr_q     <= nxt_ptr;
      hold_q    <= nxt_hold;
      timeout_q <= nxt_timeout;
    end
  end

  // Outputs come straight from flops; oe is the decoded state bit.
  assign bus.sel     = sel_q;
  assign bus.ptr     = ptr_q;
  assign bus.timeout = timeout_q;
  assign bus.oe      = (state == GRANT);

endmodule
`default_nettype wire
